rv_ctl_mw: RTL and testbench
============================

RV_CTL_MW -- requirements
Module: rv_ctl_mw

Interface
REQ-001 SHALL use one clock (clk) and an asynchronous, active-low reset (rst); all state flops clear while rst=0.
REQ-002 Param MEM_WAIT_MAX, 15: max consecutive not-ready memory cycles; 0 disables the timeout.
REQ-003 Param ENABLE_BNE, 1: 1 = BNE decoded; 0 = BNE treated as unimplemented.
REQ-004 Param CNT_W, 32: width of instret.
REQ-005 clk  in  1  clock, rising edge.
REQ-006 rst  in  1  async reset, active-low.
REQ-007 instr  in  32  current IR contents.
REQ-008 zero  in  1  ALU result == 0.
REQ-009 mem_ready  in  1  memory completes the access this cycle.
REQ-010 mem_req  out  1  memory access request.
REQ-011 memrw  out  1  1 = write.
REQ-012 pcsource  out  1  PC_INC / PC_ALU.
REQ-013 pcwrite  out  1  PC load enable.
REQ-014 pccen  out  1  PC-copy load enable.
REQ-015 irwrite  out  1  IR load enable.
REQ-016 wbsel  out  2  WB_PC / WB_ALUOUT / WB_MDR.
REQ-017 regwen  out  1  register-file write enable.
REQ-018 immsel  out  2  IMM_B / IMM_L / IMM_S / IMM_J.
REQ-019 asel  out  2  ALUA_REG / ALUA_PCC.
REQ-020 bsel  out  2  ALUB_REG / ALUB_IMM.
REQ-021 alusel  out  4  ALU operation.
REQ-022 mdrwrite  out  1  MDR load enable.
REQ-023 retire  out  1  one-cycle pulse per completed instruction.
REQ-024 illegal  out  1  one-cycle pulse in DECODE on an unimplemented opcode.
REQ-025 fault  out  1  sticky memory-timeout flag.
REQ-026 instret  out  CNT_W  retired-instruction count.

Function
REQ-027 Decode key SHALL be {instr[6:0], instr[14:12]}, matched against the team-shared LW, SW, ALU, BEQ, BNE, JAL and ADDI patterns, with don't-care bits honoured.
REQ-028 States SHALL be FETCH, DECODE, LSW_ADDR, LW_MEM, LW_WB, SW_MEM, RTYPE_ALU, RTYPE_WB, BR_EXEC, JAL_EXEC, ADDI_EXEC and FAULT.
REQ-029 Default outputs in every state SHALL be: all enables 0, mem_req=0, pcsource=PC_INC, wbsel=WB_PC, immsel=IMM_B, asel=ALUA_REG, bsel=ALUB_REG, alusel=ALU_ADD.
REQ-030 FETCH: mem_req=1; stay while mem_ready=0; when mem_ready=1, irwrite=pcwrite=pccen=1 that cycle and next state is DECODE.
REQ-031 DECODE: asel=ALUA_PCC, bsel=ALUB_IMM, immsel=IMM_B; LW/SW->LSW_ADDR, ALU->RTYPE_ALU, BEQ/BNE->BR_EXEC, JAL->JAL_EXEC, ADDI->ADDI_EXEC, otherwise illegal=1 and ->FETCH.
REQ-032 LSW_ADDR: bsel=ALUB_IMM; immsel=IMM_L for LW, else IMM_S; LW->LW_MEM, else SW_MEM.
REQ-033 LW_MEM: mem_req=1; mdrwrite=mem_ready; leave to LW_WB on mem_ready; LW_WB: wbsel=WB_MDR, regwen=1, ->FETCH.
REQ-034 SW_MEM: mem_req=memrw=1 until mem_ready; on mem_ready ->FETCH.
REQ-035 RTYPE_ALU: alusel={instr[14:12],instr[30]}, ->RTYPE_WB; ADDI_EXEC: bsel=ALUB_IMM, immsel=IMM_L, ALU_ADD, ->RTYPE_WB; RTYPE_WB: wbsel=WB_ALUOUT, regwen=1, ->FETCH.
REQ-036 BR_EXEC: ALU_SUB, pcsource=PC_ALU, pcwrite=zero for BEQ and ~zero for BNE, ->FETCH.
REQ-037 JAL_EXEC: asel=ALUA_PCC, bsel=ALUB_IMM, immsel=IMM_J, pcsource=PC_ALU, pcwrite=regwen=1, wbsel=WB_PC, ->FETCH.
REQ-038 Wait counter SHALL count consecutive mem_req=1 & mem_ready=0 cycles and clear on any ready or state change.
REQ-039 When MEM_WAIT_MAX≠0, the MEM_WAIT_MAX-th consecutive not-ready cycle SHALL select FAULT as next state.
REQ-040 FAULT SHALL hold default outputs, set fault=1 and remain until reset.
REQ-041 retire=1 in LW_WB, RTYPE_WB, BR_EXEC, JAL_EXEC, and SW_MEM when mem_ready=1; never on illegal or timeout.
REQ-042 instret SHALL increment on retire and wrap modulo 2^CNT_W.

Reset
REQ-043 On rst=0 (any state, including mid-wait): state=FETCH, wait counter=0, fault=0, instret=0, all outputs at defaults.
REQ-044 The first mem_req SHALL assert in the first cycle after rst rises.

Verification
REQ-045 ADD 0x002081B3, mem_ready=1 -> FETCH, DECODE, RTYPE_ALU (alusel=0000), RTYPE_WB (regwen=1, retire=1); instret=1.
REQ-046 Fetch with mem_ready low 3 cycles -> mem_req high 4 cycles; irwrite only in the 4th.
REQ-047 MEM_WAIT_MAX=4, mem_ready=0 -> 4 FETCH cycles, then fault=1 and mem_req=0 permanently.
REQ-048 BEQ 0x00208463 with zero=0 -> pcwrite=0; BNE 0x00209463 with zero=0 -> pcwrite=1; ENABLE_BNE=0 with BNE -> illegal=1.
REQ-049 rst low during LW_MEM wait -> no mdrwrite; restart in FETCH; instret=0.
REQ-050 CNT_W=4, 16 retired ADDs -> instret=0.

Source files
------------

// File: rtl/rv_ctl_mw.sv
// rtl/rv_ctl_mw.sv - multi-cycle RISC-V control FSM with memory-wait timeout
//
// Purpose: sequences fetch/decode/execute for LW, SW, R-type ALU, BEQ, BNE,
// JAL and ADDI. Drives datapath enables and mux selects, counts retired
// instructions, and traps stalled memory accesses into a sticky FAULT state.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   instr      in   current IR contents (decode key {instr[6:0], instr[14:12]})
//   zero       in   ALU result == 0
//   mem_ready  in   memory completes the access this cycle
//   mem_req    out  memory access request
//   memrw      out  1 = write
//   pcsource   out  PC_INC / PC_ALU
//   pcwrite    out  PC load enable
//   pccen      out  PC-copy load enable
//   irwrite    out  IR load enable
//   wbsel      out  WB_PC / WB_ALUOUT / WB_MDR
//   regwen     out  register-file write enable
//   immsel     out  IMM_B / IMM_L / IMM_S / IMM_J
//   asel       out  ALUA_REG / ALUA_PCC
//   bsel       out  ALUB_REG / ALUB_IMM
//   alusel     out  ALU operation
//   mdrwrite   out  MDR load enable
//   retire     out  one-cycle pulse per completed instruction
//   illegal    out  one-cycle pulse in DECODE on an unimplemented opcode
//   fault      out  sticky memory-timeout flag
//   instret    out  retired-instruction count (wraps)

module rv_ctl_mw #(
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter bit          ENABLE_BNE   = 1'b1,
    parameter int          CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             memrw,
    output logic             pcsource,
    output logic             pcwrite,
    output logic             pccen,
    output logic             irwrite,
    output logic [1:0]       wbsel,
    output logic             regwen,
    output logic [1:0]       immsel,
    output logic [1:0]       asel,
    output logic [1:0]       bsel,
    output logic [3:0]       alusel,
    output logic             mdrwrite,
    output logic             retire,
    output logic             illegal,
    output logic             fault,
    output logic [CNT_W-1:0] instret
);

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_LSW_ADDR  = 4'd2;
    localparam logic [3:0] S_LW_MEM    = 4'd3;
    localparam logic [3:0] S_LW_WB     = 4'd4;
    localparam logic [3:0] S_SW_MEM    = 4'd5;
    localparam logic [3:0] S_RTYPE_ALU = 4'd6;
    localparam logic [3:0] S_RTYPE_WB  = 4'd7;
    localparam logic [3:0] S_BR_EXEC   = 4'd8;
    localparam logic [3:0] S_JAL_EXEC  = 4'd9;
    localparam logic [3:0] S_ADDI_EXEC = 4'd10;
    localparam logic [3:0] S_FAULT     = 4'd11;

    localparam logic       PC_INC    = 1'b0;
    localparam logic       PC_ALU    = 1'b1;
    localparam logic [1:0] WB_PC     = 2'd0;
    localparam logic [1:0] WB_ALUOUT = 2'd1;
    localparam logic [1:0] WB_MDR    = 2'd2;
    localparam logic [1:0] IMM_B     = 2'd0;
    localparam logic [1:0] IMM_L     = 2'd1;
    localparam logic [1:0] IMM_S     = 2'd2;
    localparam logic [1:0] IMM_J     = 2'd3;
    localparam logic [1:0] ALUA_REG  = 2'd0;
    localparam logic [1:0] ALUA_PCC  = 2'd1;
    localparam logic [1:0] ALUB_REG  = 2'd0;
    localparam logic [1:0] ALUB_IMM  = 2'd1;
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;

    // The counter only has to reach MEM_WAIT_MAX-1: the next not-ready
    // cycle leaves the state, which clears it.
    localparam int WCW         = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam int WAIT_LAST_I = (MEM_WAIT_MAX > 0) ? int'(MEM_WAIT_MAX) - 1 : 0;
    localparam logic [WCW-1:0] WAIT_LAST = WAIT_LAST_I[WCW-1:0];

    logic [3:0]       state_q, state_d;
    logic [WCW-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0] instret_q;

    logic [9:0] key;
    logic       is_lw, is_sw, is_alu, is_beq, is_bne, is_jal, is_addi;

    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    assign key = {instr[6:0], instr[14:12]};

    always_comb begin
        is_lw   = 1'b0;
        is_sw   = 1'b0;
        is_alu  = 1'b0;
        is_beq  = 1'b0;
        is_bne  = 1'b0;
        is_jal  = 1'b0;
        is_addi = 1'b0;
        casez (key)
            10'b0000011_010: is_lw   = 1'b1;
            10'b0100011_010: is_sw   = 1'b1;
            10'b0110011_???: is_alu  = 1'b1;
            10'b1100011_000: is_beq  = 1'b1;
            10'b1100011_001: is_bne  = ENABLE_BNE;
            10'b1101111_???: is_jal  = 1'b1;
            10'b0010011_000: is_addi = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = '0;
        mem_req  = 1'b0;
        memrw    = 1'b0;
        pcsource = PC_INC;
        pcwrite  = 1'b0;
        pccen    = 1'b0;
        irwrite  = 1'b0;
        wbsel    = WB_PC;
        regwen   = 1'b0;
        immsel   = IMM_B;
        asel     = ALUA_REG;
        bsel     = ALUB_REG;
        alusel   = ALU_ADD;
        mdrwrite = 1'b0;
        retire   = 1'b0;
        illegal  = 1'b0;

        // Outputs are held at defaults while reset is asserted, even though
        // the state register already sits in FETCH.
        if (rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        irwrite = 1'b1;
                        pcwrite = 1'b1;
                        pccen   = 1'b1;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    asel   = ALUA_PCC;
                    bsel   = ALUB_IMM;
                    immsel = IMM_B;
                    if (is_lw || is_sw)        state_d = S_LSW_ADDR;
                    else if (is_alu)           state_d = S_RTYPE_ALU;
                    else if (is_beq || is_bne) state_d = S_BR_EXEC;
                    else if (is_jal)           state_d = S_JAL_EXEC;
                    else if (is_addi)          state_d = S_ADDI_EXEC;
                    else begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_LSW_ADDR: begin
                    bsel    = ALUB_IMM;
                    immsel  = is_lw ? IMM_L : IMM_S;
                    state_d = is_lw ? S_LW_MEM : S_SW_MEM;
                end
                S_LW_MEM: begin
                    mem_req  = 1'b1;
                    mdrwrite = mem_ready;
                    if (mem_ready) state_d = S_LW_WB;
                end
                S_LW_WB: begin
                    wbsel   = WB_MDR;
                    regwen  = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
                S_SW_MEM: begin
                    mem_req = 1'b1;
                    memrw   = 1'b1;
                    if (mem_ready) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_RTYPE_ALU: begin
                    alusel  = {instr[14:12], instr[30]};
                    state_d = S_RTYPE_WB;
                end
                S_ADDI_EXEC: begin
                    bsel    = ALUB_IMM;
                    immsel  = IMM_L;
                    alusel  = ALU_ADD;
                    state_d = S_RTYPE_WB;
                end
                S_RTYPE_WB: begin
                    wbsel   = WB_ALUOUT;
                    regwen  = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
                S_BR_EXEC: begin
                    alusel   = ALU_SUB;
                    pcsource = PC_ALU;
                    pcwrite  = is_bne ? ~zero : zero;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end
                S_JAL_EXEC: begin
                    asel     = ALUA_PCC;
                    bsel     = ALUB_IMM;
                    immsel   = IMM_J;
                    pcsource = PC_ALU;
                    pcwrite  = 1'b1;
                    regwen   = 1'b1;
                    wbsel    = WB_PC;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_FETCH;
            endcase

            // The MEM_WAIT_MAX-th consecutive stalled cycle overrides the
            // normal transition; retire cannot fire here since it needs ready.
            if ((MEM_WAIT_MAX != 0) && mem_req && !mem_ready && (wait_q == WAIT_LAST)) begin
                state_d = S_FAULT;
            end

            if ((MEM_WAIT_MAX != 0) && mem_req && !mem_ready && (state_d == state_q)) begin
                wait_d = wait_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (retire) instret_q <= instret_q + 1'b1;
        end
    end

    assign fault   = (state_q == S_FAULT);
    assign instret = instret_q;

endmodule

// File: tb/tb_rv_ctl_mw.sv
// tb/tb_rv_ctl_mw.sv - directed self-checking bench for rv_ctl_mw
module tb_rv_ctl_mw;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_ADDI = 32'h00100093;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_BNE  = 32'h00209463;
    localparam logic [31:0] I_LW   = 32'h0000A103;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_JAL  = 32'h008000EF;
    localparam logic [31:0] I_BAD  = 32'h00000000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;

    // Instance A: MEM_WAIT_MAX=4, BNE decoded, 4-bit instret
    logic       a_mem_req, a_memrw, a_pcsource, a_pcwrite, a_pccen, a_irwrite;
    logic [1:0] a_wbsel, a_immsel, a_asel, a_bsel;
    logic       a_regwen, a_mdrwrite, a_retire, a_illegal, a_fault;
    logic [3:0] a_alusel;
    logic [3:0] a_instret;

    // Instance B: timeout disabled, BNE unimplemented, 32-bit instret
    logic        b_mem_req, b_memrw, b_pcsource, b_pcwrite, b_pccen, b_irwrite;
    logic [1:0]  b_wbsel, b_immsel, b_asel, b_bsel;
    logic        b_regwen, b_mdrwrite, b_retire, b_illegal, b_fault;
    logic [3:0]  b_alusel;
    logic [31:0] b_instret;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rv_ctl_mw #(.MEM_WAIT_MAX(4), .ENABLE_BNE(1'b1), .CNT_W(4)) u_a (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_req(a_mem_req), .memrw(a_memrw), .pcsource(a_pcsource), .pcwrite(a_pcwrite),
        .pccen(a_pccen), .irwrite(a_irwrite), .wbsel(a_wbsel), .regwen(a_regwen),
        .immsel(a_immsel), .asel(a_asel), .bsel(a_bsel), .alusel(a_alusel),
        .mdrwrite(a_mdrwrite), .retire(a_retire), .illegal(a_illegal), .fault(a_fault),
        .instret(a_instret)
    );

    rv_ctl_mw #(.MEM_WAIT_MAX(0), .ENABLE_BNE(1'b0), .CNT_W(32)) u_b (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_req(b_mem_req), .memrw(b_memrw), .pcsource(b_pcsource), .pcwrite(b_pcwrite),
        .pccen(b_pccen), .irwrite(b_irwrite), .wbsel(b_wbsel), .regwen(b_regwen),
        .immsel(b_immsel), .asel(b_asel), .bsel(b_bsel), .alusel(b_alusel),
        .mdrwrite(b_mdrwrite), .retire(b_retire), .illegal(b_illegal), .fault(b_fault),
        .instret(b_instret)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; instr = I_ADD; zero = 1'b0; mem_ready = 1'b1;
        nxt(); nxt(); #2;
        chk1("rst_mem_req",  a_mem_req, 1'b0);
        chk1("rst_irwrite",  a_irwrite, 1'b0);
        chk1("rst_fault",    a_fault, 1'b0);
        chkn("rst_instret",  32'(a_instret), 32'd0);
        chk1("rst_b_memreq", b_mem_req, 1'b0);

        // ADD, memory always ready
        nxt(); rst = 1'b1; #2;
        chk1("add_f_memreq", a_mem_req, 1'b1);
        chk1("add_f_irw",    a_irwrite, 1'b1);
        chk1("add_f_pcw",    a_pcwrite, 1'b1);
        chk1("add_f_pccen",  a_pccen, 1'b1);
        nxt(); #2;
        chkn("add_d_asel",   32'(a_asel), 32'd1);
        chkn("add_d_bsel",   32'(a_bsel), 32'd1);
        chk1("add_d_ill",    a_illegal, 1'b0);
        chk1("add_d_irw",    a_irwrite, 1'b0);
        nxt(); #2;
        chkn("add_alu_sel",  32'(a_alusel), 32'd0);
        chk1("add_alu_rwen", a_regwen, 1'b0);
        nxt(); #2;
        chk1("add_wb_rwen",  a_regwen, 1'b1);
        chk1("add_wb_ret",   a_retire, 1'b1);
        chkn("add_wb_wbsel", 32'(a_wbsel), 32'd1);
        nxt(); mem_ready = 1'b0; instr = I_ADDI; #2;
        chkn("add_instret",  32'(a_instret), 32'd1);
        chkn("add_b_instret", b_instret, 32'd1);

        // Fetch stalled three cycles, ready on the fourth
        chk1("stall1_req", a_mem_req, 1'b1);
        chk1("stall1_irw", a_irwrite, 1'b0);
        nxt(); #2;
        chk1("stall2_req", a_mem_req, 1'b1);
        chk1("stall2_irw", a_irwrite, 1'b0);
        nxt(); #2;
        chk1("stall3_req", a_mem_req, 1'b1);
        chk1("stall3_irw", a_irwrite, 1'b0);
        nxt(); mem_ready = 1'b1; #2;
        chk1("stall4_req",   a_mem_req, 1'b1);
        chk1("stall4_irw",   a_irwrite, 1'b1);
        chk1("stall4_fault", a_fault, 1'b0);
        nxt(); nxt(); #2;
        chkn("addi_bsel",   32'(a_bsel), 32'd1);
        chkn("addi_immsel", 32'(a_immsel), 32'd1);
        chkn("addi_alusel", 32'(a_alusel), 32'd0);
        nxt(); #2;
        chk1("addi_wb_ret", a_retire, 1'b1);
        nxt(); instr = I_BEQ; zero = 1'b0; #2;
        chkn("addi_instret", 32'(a_instret), 32'd2);

        // BEQ not taken, then BNE taken (A) / illegal (B)
        nxt(); nxt(); #2;
        chkn("beq_alusel", 32'(a_alusel), 32'd1);
        chk1("beq_pcsrc",  a_pcsource, 1'b1);
        chk1("beq_pcw",    a_pcwrite, 1'b0);
        chk1("beq_ret",    a_retire, 1'b1);
        chk1("beq_b_pcw",  b_pcwrite, 1'b0);
        nxt(); instr = I_BNE; nxt(); #2;
        chk1("bne_d_ill",   a_illegal, 1'b0);
        chk1("bne_b_ill",   b_illegal, 1'b1);
        chk1("bne_b_ret",   b_retire, 1'b0);
        nxt(); #2;
        chk1("bne_pcw",     a_pcwrite, 1'b1);
        chk1("bne_b_fetch", b_mem_req, 1'b1);
        nxt(); #2;
        chkn("bne_instret",   32'(a_instret), 32'd4);
        chkn("bne_b_instret", b_instret, 32'd3);

        // Asynchronous reset between edges
        rst = 1'b0; #1;
        chk1("arst_req",     a_mem_req, 1'b0);
        chkn("arst_instret", 32'(a_instret), 32'd0);
        nxt(); rst = 1'b1; instr = I_LW; mem_ready = 1'b1;

        // LW, SW, JAL, illegal opcode
        nxt(); nxt(); #2;
        chkn("lw_addr_imm",  32'(a_immsel), 32'd1);
        chkn("lw_addr_bsel", 32'(a_bsel), 32'd1);
        nxt(); #2;
        chk1("lw_mem_req",  a_mem_req, 1'b1);
        chk1("lw_mem_mdrw", a_mdrwrite, 1'b1);
        chk1("lw_mem_rw",   a_memrw, 1'b0);
        nxt(); #2;
        chkn("lw_wb_wbsel", 32'(a_wbsel), 32'd2);
        chk1("lw_wb_rwen",  a_regwen, 1'b1);
        chk1("lw_wb_ret",   a_retire, 1'b1);
        nxt(); instr = I_SW; nxt(); nxt(); #2;
        chkn("sw_addr_imm", 32'(a_immsel), 32'd2);
        mem_ready = 1'b0;
        nxt(); #2;
        chk1("sw_wait_req", a_mem_req, 1'b1);
        chk1("sw_wait_rw",  a_memrw, 1'b1);
        chk1("sw_wait_ret", a_retire, 1'b0);
        nxt(); mem_ready = 1'b1; #2;
        chk1("sw_done_ret", a_retire, 1'b1);
        chk1("sw_done_rw",  a_memrw, 1'b1);
        nxt(); instr = I_JAL; nxt(); nxt(); #2;
        chkn("jal_imm",   32'(a_immsel), 32'd3);
        chk1("jal_pcsrc", a_pcsource, 1'b1);
        chk1("jal_pcw",   a_pcwrite, 1'b1);
        chk1("jal_rwen",  a_regwen, 1'b1);
        chkn("jal_wbsel", 32'(a_wbsel), 32'd0);
        chkn("jal_asel",  32'(a_asel), 32'd1);
        chk1("jal_ret",   a_retire, 1'b1);
        nxt(); instr = I_BAD; nxt(); #2;
        chk1("bad_ill", a_illegal, 1'b1);
        chk1("bad_ret", a_retire, 1'b0);
        nxt(); instr = I_LW; #2;
        chkn("bad_instret", 32'(a_instret), 32'd3);

        // Reset while LW_MEM is stalled
        nxt(); nxt(); mem_ready = 1'b0; nxt(); #2;
        chk1("lwst_req",  a_mem_req, 1'b1);
        chk1("lwst_mdrw", a_mdrwrite, 1'b0);
        nxt(); #2;
        rst = 1'b0; #1;
        chk1("lwrst_mdrw",    a_mdrwrite, 1'b0);
        chk1("lwrst_req",     a_mem_req, 1'b0);
        chkn("lwrst_instret", 32'(a_instret), 32'd0);

        // Restart with memory never ready: A times out after 4 cycles
        nxt(); rst = 1'b1; #2;
        chk1("to1_req", a_mem_req, 1'b1);
        chk1("to1_irw", a_irwrite, 1'b0);
        nxt(); nxt(); nxt(); #2;
        chk1("to4_req",   a_mem_req, 1'b1);
        chk1("to4_fault", a_fault, 1'b0);
        nxt(); #2;
        chk1("to5_fault", a_fault, 1'b1);
        chk1("to5_req",   a_mem_req, 1'b0);
        repeat (20) nxt();
        mem_ready = 1'b1; #2;
        chk1("to_late_fault", a_fault, 1'b1);
        chk1("to_late_req",   a_mem_req, 1'b0);
        chk1("to_late_irw",   a_irwrite, 1'b0);
        chk1("to_b_req",      b_mem_req, 1'b1);
        chk1("to_b_fault",    b_fault, 1'b0);

        // 4-bit instret wraps after 16 ADDs
        rst = 1'b0; nxt(); rst = 1'b1; instr = I_ADD; mem_ready = 1'b1;
        repeat (15 * 4) nxt();
        #2;
        chkn("wrap15_a", 32'(a_instret), 32'd15);
        repeat (4) nxt();
        #2;
        chkn("wrap16_a", 32'(a_instret), 32'd0);
        chkn("wrap16_b", b_instret, 32'd16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
